// File: rtl/rv32i_trap_ctrl_pkg.sv
// rv32i_trap_ctrl_pkg: CSR command encodings, machine CSR addresses and trap FSM states
package rv32i_trap_ctrl_pkg;
  localparam logic [2:0] CSR_NOP   = 3'b000;
  localparam logic [2:0] CSR_WRITE = 3'b001;
  localparam logic [2:0] CSR_SET   = 3'b010;
  localparam logic [2:0] CSR_CLEAR = 3'b011;
  localparam logic [2:0] CSR_READ  = 3'b100;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [31:0] MIE_MASK = 32'h0000_0008;
  typedef enum logic [3:0] {
    IDLE, SAVE_EPC, SAVE_CAUSE, CLR_MIE, RD_TVEC, WAIT_TVEC,
    RD_EPC, WAIT_EPC, SET_MIE, REDIRECT
  } state_e;
endpackage

// File: rtl/rv32i_trap_ctrl_if.sv
// rv32i_trap_ctrl_if: trap/mret requests, pipeline CSR port, CSR unit port and redirect
interface rv32i_trap_ctrl_if;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        trap_ack;
  logic        mret_req;
  logic        mret_ack;
  logic        pipe_csr_en;
  logic [11:0] pipe_csr_addr;
  logic [31:0] pipe_csr_wdata;
  logic [2:0]  pipe_csr_cmd;
  logic        pipe_csr_gnt;
  logic        csr_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [2:0]  csr_cmd;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  modport slave (
    input  trap_req, trap_cause, trap_pc, mret_req,
           pipe_csr_en, pipe_csr_addr, pipe_csr_wdata, pipe_csr_cmd, csr_rdata,
    output trap_ack, mret_ack, pipe_csr_gnt, csr_en, csr_addr, csr_wdata, csr_cmd,
           redirect_valid, redirect_pc, busy
  );
  modport master (
    output trap_req, trap_cause, trap_pc, mret_req,
           pipe_csr_en, pipe_csr_addr, pipe_csr_wdata, pipe_csr_cmd, csr_rdata,
    input  trap_ack, mret_ack, pipe_csr_gnt, csr_en, csr_addr, csr_wdata, csr_cmd,
           redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/rv32i_trap_vec_calc.sv
// rv32i_trap_vec_calc: trap target from mtvec/cause; vectored mode only with RV32I_TRAP_VECTORED_EN
module rv32i_trap_vec_calc (
  input  logic [31:0] mtvec,
  input  logic [31:0] cause,
  output logic [31:0] pc
);
  logic [31:0] base;
  assign base = {mtvec[31:2], 2'b00};
`ifdef RV32I_TRAP_VECTORED_EN
  logic unused_bits;
  assign unused_bits = cause[30];
  // 4*cause[30:0] wraps mod 2^32, so cause[30] falls off the top
  assign pc = (mtvec[1:0] == 2'b01 && cause[31]) ? base + {cause[29:0], 2'b00} : base;
`else
  logic unused_bits;
  assign unused_bits = ^{mtvec[1:0], cause};
  assign pc = base;
`endif
endmodule

// File: rtl/rv32i_trap_ctrl.sv
// rv32i_trap_ctrl: sequences machine-mode trap entry and mret through a shared CSR port
module rv32i_trap_ctrl
  import rv32i_trap_ctrl_pkg::*;
(
  input logic clk,
  input logic rst,
  rv32i_trap_ctrl_if.slave bus
);
  state_e state, next;
  logic [31:0] pc_q, cause_q, vec_pc;
  logic idle, gnt;
  assign idle = state == IDLE && !rst;
  assign gnt = idle && bus.pipe_csr_en && !bus.trap_req && !bus.mret_req;
  rv32i_trap_vec_calc u_vec (.mtvec(bus.csr_rdata), .cause(cause_q), .pc(vec_pc));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q <= '0;
      cause_q <= '0;
      bus.redirect_pc <= '0;
    end else begin
      if (state == IDLE && bus.trap_req) begin
        pc_q <= bus.trap_pc;
        cause_q <= bus.trap_cause;
      end
      if (state == WAIT_TVEC) bus.redirect_pc <= vec_pc;
      else if (state == WAIT_EPC) bus.redirect_pc <= {bus.csr_rdata[31:2], 2'b00};
    end
  always_comb begin
    next = state;
    case (state)
      IDLE:       next = bus.trap_req ? SAVE_EPC : bus.mret_req ? RD_EPC : IDLE;
      SAVE_EPC:   next = SAVE_CAUSE;
      SAVE_CAUSE: next = CLR_MIE;
      CLR_MIE:    next = RD_TVEC;
      RD_TVEC:    next = WAIT_TVEC;
      WAIT_TVEC:  next = REDIRECT;
      RD_EPC:     next = WAIT_EPC;
      WAIT_EPC:   next = SET_MIE;
      SET_MIE:    next = REDIRECT;
      default:    next = IDLE;
    endcase
  end
  always_comb begin
    bus.trap_ack = idle && bus.trap_req;
    bus.mret_ack = idle && bus.mret_req && !bus.trap_req;
    bus.pipe_csr_gnt = gnt;
    bus.redirect_valid = state == REDIRECT;
    bus.busy = state != IDLE;
    bus.csr_en = 1'b1;
    bus.csr_addr = '0;
    bus.csr_wdata = '0;
    bus.csr_cmd = CSR_NOP;
    case (state)
      IDLE: begin
        bus.csr_en = gnt;
        bus.csr_addr = gnt ? bus.pipe_csr_addr : '0;
        bus.csr_wdata = gnt ? bus.pipe_csr_wdata : '0;
        bus.csr_cmd = gnt ? bus.pipe_csr_cmd : CSR_NOP;
      end
      SAVE_EPC: begin
        bus.csr_addr = CSR_MEPC;
        bus.csr_wdata = pc_q;
        bus.csr_cmd = CSR_WRITE;
      end
      SAVE_CAUSE: begin
        bus.csr_addr = CSR_MCAUSE;
        bus.csr_wdata = cause_q;
        bus.csr_cmd = CSR_WRITE;
      end
      CLR_MIE: begin
        bus.csr_addr = CSR_MSTATUS;
        bus.csr_wdata = MIE_MASK;
        bus.csr_cmd = CSR_CLEAR;
      end
      RD_TVEC: begin
        bus.csr_addr = CSR_MTVEC;
        bus.csr_cmd = CSR_READ;
      end
      RD_EPC: begin
        bus.csr_addr = CSR_MEPC;
        bus.csr_cmd = CSR_READ;
      end
      SET_MIE: begin
        bus.csr_addr = CSR_MSTATUS;
        bus.csr_wdata = MIE_MASK;
        bus.csr_cmd = CSR_SET;
      end
      default: bus.csr_en = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_rv32i_trap_ctrl.sv
// tb_rv32i_trap_ctrl: directed trap/mret/arbitration/reset checks against a small CSR file model
module tb_rv32i_trap_ctrl;
  import rv32i_trap_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] mstatus, mtvec, mepc, mcause, exp_vec;
  rv32i_trap_ctrl_if bus ();
  rv32i_trap_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] upd(input logic [31:0] old, input logic [11:0] a);
    if (!bus.csr_en || bus.csr_addr != a) return old;
    case (bus.csr_cmd)
      CSR_WRITE: return bus.csr_wdata;
      CSR_SET:   return old | bus.csr_wdata;
      CSR_CLEAR: return old & ~bus.csr_wdata;
      default:   return old;
    endcase
  endfunction

  function automatic logic [31:0] rd(input logic [11:0] a);
    case (a)
      CSR_MSTATUS: return mstatus;
      CSR_MTVEC:   return mtvec;
      CSR_MEPC:    return mepc;
      CSR_MCAUSE:  return mcause;
      default:     return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    mstatus <= upd(mstatus, CSR_MSTATUS);
    mtvec <= upd(mtvec, CSR_MTVEC);
    mepc <= upd(mepc, CSR_MEPC);
    mcause <= upd(mcause, CSR_MCAUSE);
    if (bus.csr_en && bus.csr_cmd == CSR_READ) bus.csr_rdata <= rd(bus.csr_addr);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pwrite(input logic [11:0] a, input logic [31:0] d);
    bus.pipe_csr_en = 1'b1;
    bus.pipe_csr_addr = a;
    bus.pipe_csr_wdata = d;
    bus.pipe_csr_cmd = CSR_WRITE;
    #1;
    chk("pipe_gnt", bus.pipe_csr_gnt, 1);
    chk("pipe_passthru_addr", bus.csr_addr, a);
    chk("pipe_passthru_wdata", bus.csr_wdata, d);
    tick();
    bus.pipe_csr_en = 1'b0;
    #1;
  endtask

  initial begin
`ifdef RV32I_TRAP_VECTORED_EN
    exp_vec = 32'h0000_021C;
`else
    exp_vec = 32'h0000_0200;
`endif
    bus.trap_req = 1'b1;
    bus.trap_cause = '0;
    bus.trap_pc = '0;
    bus.mret_req = 1'b0;
    bus.pipe_csr_en = 1'b1;
    bus.pipe_csr_addr = CSR_MTVEC;
    bus.pipe_csr_wdata = '0;
    bus.pipe_csr_cmd = CSR_WRITE;
    bus.csr_rdata = '0;
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_redirect_valid", bus.redirect_valid, 0);
    chk("rst_redirect_pc", bus.redirect_pc, 0);
    chk("rst_csr_en", bus.csr_en, 0);
    chk("rst_csr_cmd", bus.csr_cmd, 0);
    chk("rst_trap_ack", bus.trap_ack, 0);
    chk("rst_gnt", bus.pipe_csr_gnt, 0);
    bus.trap_req = 1'b0;
    bus.pipe_csr_en = 1'b0;
    rst = 1'b0;
    tick();
    pwrite(CSR_MTVEC, 32'h0000_0200);
    pwrite(CSR_MSTATUS, 32'h0000_0088);
    chk("setup_mtvec", mtvec, 32'h200);
    chk("setup_mstatus", mstatus, 32'h88);
    // trap entry with a pipeline CSR write held pending throughout
    bus.pipe_csr_en = 1'b1;
    bus.pipe_csr_addr = CSR_MTVEC;
    bus.pipe_csr_wdata = 32'h0000_0300;
    bus.pipe_csr_cmd = CSR_WRITE;
    bus.trap_req = 1'b1;
    bus.trap_pc = 32'h0000_0104;
    bus.trap_cause = 32'h0000_0002;
    #1;
    chk("trap_ack", bus.trap_ack, 1);
    chk("trap_idle_gnt", bus.pipe_csr_gnt, 0);
    chk("trap_idle_csr_en", bus.csr_en, 0);
    tick();
    bus.trap_req = 1'b0;
    bus.trap_pc = 32'hDEAD_BEEF;
    bus.trap_cause = 32'hDEAD_BEEF;
    #1;
    chk("save_epc_ack", bus.trap_ack, 0);
    chk("save_epc_busy", bus.busy, 1);
    chk("save_epc_gnt", bus.pipe_csr_gnt, 0);
    chk("save_epc_en", bus.csr_en, 1);
    chk("save_epc_cmd", bus.csr_cmd, CSR_WRITE);
    chk("save_epc_addr", bus.csr_addr, 12'h341);
    chk("save_epc_wdata", bus.csr_wdata, 32'h104);
    tick();
    chk("save_cause_cmd", bus.csr_cmd, CSR_WRITE);
    chk("save_cause_addr", bus.csr_addr, 12'h342);
    chk("save_cause_wdata", bus.csr_wdata, 32'h2);
    tick();
    chk("clr_mie_cmd", bus.csr_cmd, CSR_CLEAR);
    chk("clr_mie_addr", bus.csr_addr, 12'h300);
    chk("clr_mie_wdata", bus.csr_wdata, 32'h8);
    tick();
    chk("rd_tvec_cmd", bus.csr_cmd, CSR_READ);
    chk("rd_tvec_addr", bus.csr_addr, 12'h305);
    chk("rd_tvec_gnt", bus.pipe_csr_gnt, 0);
    tick();
    chk("wait_tvec_en", bus.csr_en, 0);
    chk("wait_tvec_cmd", bus.csr_cmd, CSR_NOP);
    chk("wait_tvec_valid", bus.redirect_valid, 0);
    tick();
    chk("trap_redirect_valid", bus.redirect_valid, 1);
    chk("trap_redirect_pc", bus.redirect_pc, 32'h200);
    chk("trap_mepc", mepc, 32'h104);
    chk("trap_mcause", mcause, 32'h2);
    chk("trap_mstatus", mstatus, 32'h80);
    tick();
    chk("trap_done_valid", bus.redirect_valid, 0);
    chk("trap_done_busy", bus.busy, 0);
    chk("trap_done_gnt", bus.pipe_csr_gnt, 1);
    chk("trap_done_pc_hold", bus.redirect_pc, 32'h200);
    tick();
    bus.pipe_csr_en = 1'b0;
    chk("pipe_mtvec", mtvec, 32'h300);
    // mret
    bus.mret_req = 1'b1;
    #1;
    chk("mret_ack", bus.mret_ack, 1);
    chk("mret_idle_busy", bus.busy, 0);
    tick();
    bus.mret_req = 1'b0;
    #1;
    chk("rd_epc_ack", bus.mret_ack, 0);
    chk("rd_epc_cmd", bus.csr_cmd, CSR_READ);
    chk("rd_epc_addr", bus.csr_addr, 12'h341);
    tick();
    chk("wait_epc_en", bus.csr_en, 0);
    tick();
    chk("set_mie_cmd", bus.csr_cmd, CSR_SET);
    chk("set_mie_addr", bus.csr_addr, 12'h300);
    chk("set_mie_wdata", bus.csr_wdata, 32'h8);
    tick();
    chk("mret_redirect_valid", bus.redirect_valid, 1);
    chk("mret_redirect_pc", bus.redirect_pc, 32'h104);
    chk("mret_mstatus", mstatus, 32'h88);
    tick();
    chk("mret_done_valid", bus.redirect_valid, 0);
    chk("mret_done_busy", bus.busy, 0);
    // simultaneous requests with a vectorable mtvec/cause
    pwrite(CSR_MTVEC, 32'h0000_0201);
    bus.trap_req = 1'b1;
    bus.mret_req = 1'b1;
    bus.trap_pc = 32'h0000_0040;
    bus.trap_cause = 32'h8000_0007;
    #1;
    chk("both_trap_ack", bus.trap_ack, 1);
    chk("both_mret_ack", bus.mret_ack, 0);
    tick();
    bus.trap_req = 1'b0;
    #1;
    chk("both_seq_mret_ack", bus.mret_ack, 0);
    chk("both_seq_busy", bus.busy, 1);
    repeat (4) tick();
    chk("both_wait_mret_ack", bus.mret_ack, 0);
    tick();
    chk("vec_redirect_valid", bus.redirect_valid, 1);
    chk("vec_redirect_pc", bus.redirect_pc, exp_vec);
    chk("vec_redirect_mret_ack", bus.mret_ack, 0);
    tick();
    chk("late_mret_ack", bus.mret_ack, 1);
    tick();
    bus.mret_req = 1'b0;
    repeat (3) tick();
    chk("late_mret_valid", bus.redirect_valid, 1);
    chk("late_mret_pc", bus.redirect_pc, 32'h40);
    tick();
    // asynchronous reset in the middle of trap entry
    bus.trap_req = 1'b1;
    bus.trap_pc = 32'h0000_0500;
    bus.trap_cause = 32'h0000_0005;
    #1;
    chk("rst_trap_ack_seen", bus.trap_ack, 1);
    tick();
    bus.trap_req = 1'b0;
    tick();
    tick();
    chk("rst_pre_clr_mie", bus.csr_cmd, CSR_CLEAR);
    rst = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_valid", bus.redirect_valid, 0);
    chk("midrst_csr_en", bus.csr_en, 0);
    chk("midrst_csr_cmd", bus.csr_cmd, CSR_NOP);
    chk("midrst_redirect_pc", bus.redirect_pc, 0);
    tick();
    rst = 1'b0;
    chk("midrst_mepc_kept", mepc, 32'h500);
    chk("midrst_mstatus_kept", mstatus, 32'h88);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midrst_no_redirect", bus.redirect_valid, 0);
    end
    chk("midrst_idle_busy", bus.busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
